// File: rtl/cdu_pkg.sv
// Shared definitions for the CDU tracking-mode sequencer: mode encoding and
// default dwell/settle/loss thresholds.
package cdu_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_COARSE = 2'd1,
        MODE_FINE1  = 2'd2,
        MODE_FINE2  = 2'd3
    } cdu_mode_e;

    localparam int DEF_CNT_W         = 6;
    localparam int DEF_ZERO_DWELL    = 2;
    localparam int DEF_COARSE_SETTLE = 8;
    localparam int DEF_FINE_SETTLE   = 16;
    localparam int DEF_LOSS_LIMIT    = 4;

endpackage

// File: rtl/dwell_counter.sv
// Tick-gated saturating counter: on a tick it counts up when i_inc is high and
// clears otherwise; o_hit flags the qualifying tick on which it reaches i_thresh.
module dwell_counter #(
    parameter int CNT_W = 6
) (
    input  logic             CLOCKH,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_thresh,
    output logic             o_hit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

    // Compare against the incremented value so the deciding tick is the one
    // that reaches the threshold; a threshold of 0 fires on the first tick.
    assign o_hit = i_tick & i_inc & (w_count_inc >= i_thresh);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; clear outranks the tick update.
    always_ff @(posedge CLOCKH) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= i_inc ? w_count_inc : '0;
        end
    end

endmodule

// File: rtl/track_mode_ctrl.sv
// Per-channel CDU tracking-mode sequencer (ZERO/COARSE/FINE1/FINE2).
// Define CDU_FINE2_EN to build the FINE2 state; otherwise FINE1 is terminal.
module track_mode_ctrl
    import cdu_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int ZERO_DWELL    = DEF_ZERO_DWELL,
    parameter int COARSE_SETTLE = DEF_COARSE_SETTLE,
    parameter int FINE_SETTLE   = DEF_FINE_SETTLE,
    parameter int LOSS_LIMIT    = DEF_LOSS_LIMIT
) (
    input  logic       CLOCKH,
    input  logic       rst,
    input  logic       _800LHI,
    input  logic       CDUZ,
    input  logic       COARSE_NULL,
    input  logic       UPLVL,
    input  logic       DNLVL,
    output logic       TLC1H,
    output logic       TLF1H,
    output logic       TLF2H,
    output logic       RSETB,
    output logic [1:0] MODE,
    output logic       MODE_CHG
);

    cdu_mode_e        r_state;
    cdu_mode_e        w_next_state;
    logic             r_tlc1h, r_tlf1h, r_rsetb, r_mode_chg;
    logic             w_loss;
    logic             w_dwell_inc, w_loss_inc;
    logic             w_dwell_hit, w_loss_hit;
    logic             w_state_chg, w_cnt_clr;
    logic [CNT_W-1:0] w_dwell_thresh;

    assign w_loss = UPLVL | DNLVL;

    // One counter serves as ZERO dwell, COARSE settle and FINE1 settle.
    always_comb begin
        w_dwell_inc    = 1'b0;
        w_loss_inc     = 1'b0;
        w_dwell_thresh = '1;
        case (r_state)
            MODE_ZERO: begin
                w_dwell_inc    = 1'b1;
                w_dwell_thresh = CNT_W'(ZERO_DWELL);
            end
            MODE_COARSE: begin
                w_dwell_inc    = COARSE_NULL;
                w_dwell_thresh = CNT_W'(COARSE_SETTLE);
            end
            MODE_FINE1: begin
`ifdef CDU_FINE2_EN
                w_dwell_inc    = ~w_loss;
`endif
                w_dwell_thresh = CNT_W'(FINE_SETTLE);
                w_loss_inc     = w_loss;
            end
`ifdef CDU_FINE2_EN
            MODE_FINE2: begin
                w_loss_inc     = w_loss;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        if (CDUZ) begin
            w_next_state = MODE_ZERO;
        end else begin
            case (r_state)
                MODE_ZERO:   if (w_dwell_hit) w_next_state = MODE_COARSE;
                MODE_COARSE: if (w_dwell_hit) w_next_state = MODE_FINE1;
                MODE_FINE1: begin
                    if (w_loss_hit)       w_next_state = MODE_COARSE;
`ifdef CDU_FINE2_EN
                    else if (w_dwell_hit) w_next_state = MODE_FINE2;
`endif
                end
`ifdef CDU_FINE2_EN
                MODE_FINE2:  if (w_loss_hit) w_next_state = MODE_FINE1;
`endif
                default:     w_next_state = MODE_ZERO;
            endcase
        end
    end

    assign w_state_chg = (w_next_state != r_state);
    assign w_cnt_clr   = CDUZ | w_state_chg;

    dwell_counter #(.CNT_W(CNT_W)) u_dwell_cnt (
        .CLOCKH   (CLOCKH),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_tick   (_800LHI),
        .i_inc    (w_dwell_inc),
        .i_thresh (w_dwell_thresh),
        .o_hit    (w_dwell_hit)
    );

    dwell_counter #(.CNT_W(CNT_W)) u_loss_cnt (
        .CLOCKH   (CLOCKH),
        .rst      (rst),
        .i_clr    (w_cnt_clr),
        .i_tick   (_800LHI),
        .i_inc    (w_loss_inc),
        .i_thresh (CNT_W'(LOSS_LIMIT)),
        .o_hit    (w_loss_hit)
    );

`ifdef CDU_FINE2_EN
    logic r_tlf2h;
`endif

    always_ff @(posedge CLOCKH) begin
        if (rst) begin
            r_state    <= MODE_ZERO;
            r_rsetb    <= 1'b1;
            r_tlc1h    <= 1'b0;
            r_tlf1h    <= 1'b0;
`ifdef CDU_FINE2_EN
            r_tlf2h    <= 1'b0;
`endif
            r_mode_chg <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rsetb    <= (w_next_state == MODE_ZERO);
            r_tlc1h    <= (w_next_state == MODE_COARSE);
            r_tlf1h    <= (w_next_state == MODE_FINE1);
`ifdef CDU_FINE2_EN
            r_tlf2h    <= (w_next_state == MODE_FINE2);
`endif
            r_mode_chg <= w_state_chg;
        end
    end

    assign RSETB    = r_rsetb;
    assign TLC1H    = r_tlc1h;
    assign TLF1H    = r_tlf1h;
`ifdef CDU_FINE2_EN
    assign TLF2H    = r_tlf2h;
`else
    assign TLF2H    = 1'b0;
`endif
    assign MODE     = r_state;
    assign MODE_CHG = r_mode_chg;

endmodule
